// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch front-end bundle: decode control, imem port, decode output
interface fetch_unit_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  modport master (
    input  stall, redirect_valid, redirect_pc, imem_rdata,
    output imem_addr, if_valid, if_pc, if_instr
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, imem_rdata,
    input  imem_addr, if_valid, if_pc, if_instr
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC, 1-cycle imem latency, stall hold buffer, redirect
// Optional performance counters enabled by defining FETCH_PERF_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master fif
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  perf_fetch_cnt,
  output logic [31:0]  perf_stall_cnt
`endif
);

  localparam logic [1:0] REFILL = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc_q;
  logic [31:0] rsp_pc_q;
  logic [31:0] hold_q;
  logic        out_valid;

  // A redirect kills whatever is on the output in the same cycle.
  assign out_valid     = (state != REFILL) && !fif.redirect_valid;
  assign fif.if_valid  = out_valid;
  assign fif.if_pc     = rsp_pc_q;
  assign fif.if_instr  = !out_valid      ? 32'h0 :
                         (state == HOLD) ? hold_q : fif.imem_rdata;
  assign fif.imem_addr = pc_q >> 2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= REFILL;
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      hold_q   <= 32'h0;
    end else if (fif.redirect_valid) begin
      state  <= REFILL;
      pc_q   <= fif.redirect_pc & 32'hFFFF_FFFC;
      hold_q <= 32'h0;
    end else begin
      case (state)
        REFILL: begin
          rsp_pc_q <= pc_q;
          pc_q     <= pc_q + 32'd4;
          state    <= RUN;
        end
        RUN: begin
          if (fif.stall) begin
            hold_q <= fif.imem_rdata;
            state  <= HOLD;
          end else begin
            rsp_pc_q <= pc_q;
            pc_q     <= pc_q + 32'd4;
          end
        end
        HOLD: begin
          // pc_q already points past the held word, so release just resumes streaming.
          if (!fif.stall) begin
            rsp_pc_q <= pc_q;
            pc_q     <= pc_q + 32'd4;
            state    <= RUN;
          end
        end
        default: state <= REFILL;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= 32'h0;
      perf_stall_cnt <= 32'h0;
    end else begin
      if (out_valid && !fif.stall) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (out_valid && fif.stall)  perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
